// File: rtl/dmem_sram_ctrl_pkg.sv
// Shared types for the data-memory SRAM controller: FSM state encoding and
// the wait-counter width.
package dmem_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_WR_HOLD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_sram_ctrl_if.sv
// MEM-stage request bus between the pipeline (master) and the SRAM controller (slave).
// Handshake: a request is valid & (re | we); while stall is high the master holds
// every request field stable; the access completes in the cycle stall drops.
interface dmem_sram_ctrl_if;
  logic        dm_valid_i;
  logic        dm_re_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [3:0]  dm_wbe_n_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_stall_o;

  modport master (
    output dm_valid_i, dm_re_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
    input  dm_rdata_o, dm_stall_o
  );

  modport slave (
    input  dm_valid_i, dm_re_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
    output dm_rdata_o, dm_stall_o
  );
endinterface

// File: rtl/dmem_store_lane.sv
// Store lane placement: replicates byte/half store data across the word so the
// enabled SRAM lanes see it, and flags stores with no enabled byte.
module dmem_store_lane (
  input  logic [3:0]  wbe_n,
  input  logic [31:0] wdata,
  output logic [31:0] lane_data,
  output logic        skip
);

  always_comb begin
    lane_data = wdata;
    skip      = (wbe_n == 4'b1111);
    case (wbe_n)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: lane_data = {4{wdata[7:0]}};
      4'b1100, 4'b0011:                   lane_data = {2{wdata[15:0]}};
      default:                            lane_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// MEM-stage responder for an external asynchronous 32-bit SRAM: multi-cycle
// reads/writes with a pipeline stall; every SRAM pin comes straight from a flop.
module dmem_sram_ctrl
  import dmem_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  dmem_sram_ctrl_if.slave    dm,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe_o,
  input  logic [31:0]        sram_dq_i,
  output state_t             dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [31:0]        rdata, rdata_nx;
  logic [SRAM_AW-1:0] addr_nx;
  logic               ce_n_nx, oe_n_nx, we_n_nx, dq_oe_nx;
  logic [3:0]         be_n_nx;
  logic [31:0]        dq_nx;
  logic [31:0]        lane_data;
  logic               lane_skip;
  logic               req, wr_req, rd_req;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{dm.dm_addr_i[31:SRAM_AW+2], dm.dm_addr_i[1:0]};

  // A simultaneous load and store request is treated as a store.
  assign req    = dm.dm_valid_i & (dm.dm_re_i | dm.dm_we_i);
  assign wr_req = req & dm.dm_we_i;
  assign rd_req = req & ~dm.dm_we_i;

  assign dm.dm_stall_o = req & (state != ST_DONE);
  assign dm.dm_rdata_o = rdata;
  assign dbg_state     = state;

  dmem_store_lane u_lane (
    .wbe_n     (dm.dm_wbe_n_i),
    .wdata     (dm.dm_wdata_i),
    .lane_data (lane_data),
    .skip      (lane_skip)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdata_nx = rdata;
    addr_nx  = sram_addr_o;
    ce_n_nx  = sram_ce_n_o;
    oe_n_nx  = sram_oe_n_o;
    we_n_nx  = sram_we_n_o;
    be_n_nx  = sram_be_n_o;
    dq_nx    = sram_dq_o;
    dq_oe_nx = sram_dq_oe_o;
    case (state)
      ST_IDLE: begin
        if (wr_req) begin
          if (lane_skip) begin
            state_nx = ST_DONE;
          end else begin
            addr_nx  = dm.dm_addr_i[SRAM_AW+1:2];
            dq_nx    = lane_data;
            be_n_nx  = dm.dm_wbe_n_i;
            ce_n_nx  = 1'b0;
            we_n_nx  = 1'b0;
            dq_oe_nx = 1'b1;
            cnt_nx   = CNT_LOAD;
            state_nx = ST_WR;
          end
        end else if (rd_req) begin
          addr_nx  = dm.dm_addr_i[SRAM_AW+1:2];
          be_n_nx  = 4'b0000;
          ce_n_nx  = 1'b0;
          oe_n_nx  = 1'b0;
          cnt_nx   = CNT_LOAD;
          state_nx = ST_RD;
        end
      end
      ST_RD: begin
        if (cnt == '0) begin
          rdata_nx = sram_dq_i;
          ce_n_nx  = 1'b1;
          oe_n_nx  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_WR: begin
        // Data keeps driving through WR_HOLD so it outlasts the we_n rising edge.
        if (cnt == '0) begin
          we_n_nx  = 1'b1;
          state_nx = ST_WR_HOLD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_WR_HOLD: begin
        ce_n_nx  = 1'b1;
        dq_oe_nx = 1'b0;
        state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rdata        <= '0;
      sram_addr_o  <= '0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_be_n_o  <= 4'b1111;
      sram_dq_o    <= '0;
      sram_dq_oe_o <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      rdata        <= rdata_nx;
      sram_addr_o  <= addr_nx;
      sram_ce_n_o  <= ce_n_nx;
      sram_oe_n_o  <= oe_n_nx;
      sram_we_n_o  <= we_n_nx;
      sram_be_n_o  <= be_n_nx;
      sram_dq_o    <= dq_nx;
      sram_dq_oe_o <= dq_oe_nx;
    end
  end

endmodule
